// File: rtl/uart_rx_frame_check_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_check_if
// Brief    : Bundle of strobes, frame configuration and results exchanged
//            between the bit sampler / RX FSM side and the frame checker.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_frame_check_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
);
   logic                  FRAME_START;
   logic                  BIT_VALID;
   logic                  SAMPLED_BIT;
   logic                  PAR_EN;
   logic [1:0]            PAR_MODE;
   logic                  STOP2;
   logic                  CLR_ERR;
   logic [DATA_WIDTH-1:0] DATA_OUT;
   logic                  DATA_VALID;
   logic                  PAR_ERR;
   logic                  STOP_ERR;
   logic [CNT_WIDTH-1:0]  PAR_ERR_CNT;
   logic [CNT_WIDTH-1:0]  STOP_ERR_CNT;
   logic                  BUSY;

   // Sampler / sink side: drives strobes and config, receives frame results
   modport master (
      output FRAME_START, BIT_VALID, SAMPLED_BIT, PAR_EN, PAR_MODE, STOP2, CLR_ERR,
      input  DATA_OUT, DATA_VALID, PAR_ERR, STOP_ERR, PAR_ERR_CNT, STOP_ERR_CNT, BUSY
   );

   // Frame checker side
   modport slave (
      input  FRAME_START, BIT_VALID, SAMPLED_BIT, PAR_EN, PAR_MODE, STOP2, CLR_ERR,
      output DATA_OUT, DATA_VALID, PAR_ERR, STOP_ERR, PAR_ERR_CNT, STOP_ERR_CNT, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_check.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_check
// Brief    : UART receive frame checker. Deserialises DATA_WIDTH data bits
//            (LSB first), checks parity (even/odd/mark/space or none) and
//            1 or 2 stop bits, reports per-frame errors and keeps saturating
//            error counters.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input wire CLK,
   input wire RST,
   uart_rx_frame_check_if.slave bus
);

   localparam int                 c_BIT_W = $clog2(DATA_WIDTH);
   localparam logic [c_BIT_W-1:0] c_LAST  = c_BIT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_par_en;
   logic [1:0]            r_par_mode;
   logic                  r_stop2;
   logic [c_BIT_W-1:0]    r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_run_par;
   logic                  r_frame_perr;
   logic                  r_frame_serr;
   logic                  r_stop_seen;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_data_valid;
   logic                  r_par_err;
   logic                  r_stop_err;
   logic [CNT_WIDTH-1:0]  r_par_err_cnt;
   logic [CNT_WIDTH-1:0]  r_stop_err_cnt;
   logic                  r_busy;

   logic w_shift;
   logic w_par_chk;
   logic w_stop_chk;
   logic w_done;
   logic w_par_exp;
   logic w_done_serr;

   // State register; reset mid-frame simply drops the frame
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state and per-cycle action strobes; FRAME_START overrides anything else
   always_comb begin
      w_state_nxt = r_state;
      w_shift     = 1'b0;
      w_par_chk   = 1'b0;
      w_stop_chk  = 1'b0;
      w_done      = 1'b0;
      if (bus.FRAME_START) begin
         w_state_nxt = DATA;
      end else begin
         case (r_state)
            IDLE: ;
            DATA: if (bus.BIT_VALID) begin
               w_shift = 1'b1;
               if (r_bit_cnt == c_LAST) w_state_nxt = r_par_en ? PARITY : STOP;
            end
            PARITY: if (bus.BIT_VALID) begin
               w_par_chk   = 1'b1;
               w_state_nxt = STOP;
            end
            STOP: if (bus.BIT_VALID) begin
               w_stop_chk = 1'b1;
               if (!r_stop2 || r_stop_seen) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Expected parity bit from the latched mode and the running data parity
   always_comb begin
      w_par_exp = 1'b0;
      case (r_par_mode)
         2'b00:   w_par_exp = r_run_par;
         2'b01:   w_par_exp = ~r_run_par;
         2'b10:   w_par_exp = 1'b1;
         default: w_par_exp = 1'b0;
      endcase
   end

   // The final stop bit is still on the line when the frame completes
   assign w_done_serr = r_frame_serr | ~bus.SAMPLED_BIT;

   // Frame datapath: config latch, deserialiser, running parity, frame error bits
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_par_en     <= 1'b0;
         r_par_mode   <= 2'b00;
         r_stop2      <= 1'b0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_run_par    <= 1'b0;
         r_frame_perr <= 1'b0;
         r_frame_serr <= 1'b0;
         r_stop_seen  <= 1'b0;
      end else if (bus.FRAME_START) begin
         r_par_en     <= bus.PAR_EN;
         r_par_mode   <= bus.PAR_MODE;
         r_stop2      <= bus.STOP2;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_run_par    <= 1'b0;
         r_frame_perr <= 1'b0;
         r_frame_serr <= 1'b0;
         r_stop_seen  <= 1'b0;
      end else begin
         if (w_shift) begin
            r_shift   <= {bus.SAMPLED_BIT, r_shift[DATA_WIDTH-1:1]};
            r_run_par <= r_run_par ^ bus.SAMPLED_BIT;
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_par_chk && (bus.SAMPLED_BIT != w_par_exp)) r_frame_perr <= 1'b1;
         if (w_stop_chk) begin
            r_stop_seen <= 1'b1;
            if (!bus.SAMPLED_BIT) r_frame_serr <= 1'b1;
         end
      end
   end

   // Result registers and saturating counters; CLR_ERR beats a same-cycle increment
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_data_out     <= '0;
         r_data_valid   <= 1'b0;
         r_par_err      <= 1'b0;
         r_stop_err     <= 1'b0;
         r_par_err_cnt  <= '0;
         r_stop_err_cnt <= '0;
         r_busy         <= 1'b0;
      end else begin
         r_data_valid <= w_done;
         r_busy       <= (w_state_nxt != IDLE);
         if (w_done) begin
            r_data_out <= r_shift;
            r_par_err  <= r_frame_perr;
            r_stop_err <= w_done_serr;
         end
         if (bus.CLR_ERR) begin
            r_par_err_cnt  <= '0;
            r_stop_err_cnt <= '0;
         end else if (w_done) begin
            if (r_frame_perr && (r_par_err_cnt != c_CNT_MAX))
               r_par_err_cnt <= r_par_err_cnt + 1'b1;
            if (w_done_serr && (r_stop_err_cnt != c_CNT_MAX))
               r_stop_err_cnt <= r_stop_err_cnt + 1'b1;
         end
      end
   end

   assign bus.DATA_OUT     = r_data_out;
   assign bus.DATA_VALID   = r_data_valid;
   assign bus.PAR_ERR      = r_par_err;
   assign bus.STOP_ERR     = r_stop_err;
   assign bus.PAR_ERR_CNT  = r_par_err_cnt;
   assign bus.STOP_ERR_CNT = r_stop_err_cnt;
   assign bus.BUSY         = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised serial frame checker for the UART receive path, between the bit sampler and the RX FSM/data sink. It takes sampled bits one strobe at a time after the start bit. While they arrive it deserialises the data field, accumulates parity, and checks the parity and stop bits. For each completed frame it presents data with per-frame error flags and keeps saturating error counters. It generalises fixed 8-bit even/odd checking: width is a parameter, parity can be disabled or set to mark/space, and 1 or 2 stop bits are supported.

## Interface
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- CNT_WIDTH, 8: width of each error counter.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- FRAME_START  in  1  one-cycle pulse: start bit validated, data bits follow.
- BIT_VALID  in  1  one-cycle strobe: SAMPLED_BIT holds the next frame bit.
- SAMPLED_BIT  in  1  sampled line value.
- PAR_EN  in  1  1 = frame contains a parity bit.
- PAR_MODE  in  2  00 even, 01 odd, 10 mark (expected 1), 11 space (expected 0).
- STOP2  in  1  0 = one stop bit, 1 = two stop bits.
- CLR_ERR  in  1  one-cycle pulse: clear both counters.
- DATA_OUT  out  DATA_WIDTH  received data, LSB first on line; holds until next frame.
- DATA_VALID  out  1  one-cycle pulse: frame complete.
- PAR_ERR  out  1  parity error of last completed frame; holds until next DATA_VALID.
- STOP_ERR  out  1  stop-bit error of last completed frame; holds until next DATA_VALID.
- PAR_ERR_CNT  out  CNT_WIDTH  saturating count of frames with PAR_ERR.
- STOP_ERR_CNT  out  CNT_WIDTH  saturating count of frames with STOP_ERR.
- BUSY  out  1  high whenever FSM is not IDLE.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE: on FRAME_START, latch PAR_EN, PAR_MODE, STOP2 into frame config. Clear bit counter, shift register, running parity, and frame error bits. Go to DATA. BIT_VALID in IDLE is ignored.
- DATA: on each BIT_VALID, shift SAMPLED_BIT into the MSB of the shift register (right shift, so the first bit ends in bit 0) and XOR it into running parity. After the DATA_WIDTH-th bit, go to PARITY if latched PAR_EN, else STOP.
- PARITY: expected bit = running parity (even), ~running parity (odd), 1 (mark), 0 (space). On BIT_VALID, set frame parity error if SAMPLED_BIT differs from expected, then go to STOP.
- STOP: on each BIT_VALID, set frame stop error if SAMPLED_BIT = 0. With latched STOP2=1, the first stop bit stays in STOP and the second completes the frame. Otherwise the first completes it.
- Completion: go to IDLE and pulse DATA_VALID. Load DATA_OUT, PAR_ERR, STOP_ERR. Increment each counter once if its frame error is set; a frame with both errors increments both.
- Counters saturate at all-ones and never wrap.
- CLR_ERR zeroes both counters. If CLR_ERR coincides with an increment, clear wins and the result is 0. CLR_ERR does not affect PAR_ERR/STOP_ERR.
- FRAME_START while not IDLE: abort the current frame (no DATA_VALID, no counter change) and restart as from IDLE with newly latched config.
- FRAME_START and BIT_VALID in the same cycle: FRAME_START wins and the bit is discarded.
- Config inputs changing mid-frame have no effect on that frame.
- PAR_EN=0: PAR_ERR is 0 at completion.

## Timing
- Reset values: DATA_OUT 0, DATA_VALID 0, PAR_ERR 0, STOP_ERR 0, both counters 0, BUSY 0, FSM IDLE. Reset mid-frame discards the frame.
- BUSY rises the cycle after FRAME_START.
- DATA_VALID pulses exactly one cycle, the cycle after the final stop-bit BIT_VALID (latency 1). DATA_OUT, PAR_ERR, STOP_ERR and the counters update on that same edge.
- A FRAME_START on the cycle DATA_VALID is high is accepted normally.
- BIT_VALID may arrive back-to-back on consecutive cycles; every strobe is consumed.
- All outputs are registered.

## Test plan
- DATA_WIDTH=8, even, 1 stop: FRAME_START, bits of 0xA5 LSB-first, parity 0, stop 1 -> one DATA_VALID, DATA_OUT=0xA5, PAR_ERR=0, STOP_ERR=0, counters 0.
- Odd parity, 0xA5 with parity bit 0 -> PAR_ERR=1, PAR_ERR_CNT=1; next good frame clears PAR_ERR to 0, count stays 1.
- STOP2=1, 0x3C, no parity, stops 1 then 0 -> DATA_VALID only after the second stop, STOP_ERR=1, STOP_ERR_CNT=1. Same frame with STOP2=0 takes one stop bit.
- Mark/space: 0x00 with parity bit 1 in mark passes; the same frame in space flags PAR_ERR. Repeat at DATA_WIDTH=5 and 9.
- CNT_WIDTH=2: 4 parity-error frames -> count 3 (saturated). CLR_ERR coincident with a 5th error completion -> count 0.
- FRAME_START after 4 data bits, then a full good frame 0x5A -> exactly one DATA_VALID with 0x5A. RST low mid-frame -> all outputs at reset values, no DATA_VALID.
